// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the handshaked data memory.
//   LATENCY_MAX  : upper bound on the read pipeline depth
//   mem_resp_t   : response record {err, rdata} at the default word width
//   addr_chk_t   : result of addr_check {misaligned, out_of_range}
//   addr_check() : classifies a byte address for a given lane offset and depth
package data_mem_pkg;

    localparam int unsigned LATENCY_MAX    = 4;
    localparam int unsigned DATA_W_DEFAULT = 32;

    typedef struct packed {
        logic                      err;
        logic [DATA_W_DEFAULT-1:0] rdata;
    } mem_resp_t;

    typedef struct packed {
        logic misaligned;
        logic out_of_range;
    } addr_chk_t;

    // ofs = log2(bytes per word); depth = number of words
    function automatic addr_chk_t addr_check(input logic [63:0] addr,
                                             input int unsigned ofs,
                                             input int unsigned depth);
        logic [63:0] mask;
        addr_chk_t   r;
        mask           = (64'd1 << ofs) - 64'd1;
        r.misaligned   = (addr & mask) != '0;
        r.out_of_range = (addr >> ofs) >= 64'(depth);
        return r;
    endfunction

endpackage

// File: rtl/data_mem_hs_resp_fifo.sv
// Synchronous FIFO holding responses until the consumer takes them.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   push/wdata : write an entry
//   pop/rdata  : rdata is the head entry; pop removes it
//   full/empty/count : occupancy status
// Same-cycle push and pop are allowed, including when full.
module resp_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = storage[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            storage[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (do_pop && !do_push) count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/data_mem_hs.sv
// Word-addressed data memory with valid/ready request and response channels.
// Ports:
//   clk, rst_n               : clock, synchronous active-low reset
//   req_valid/req_ready      : request handshake
//   req_we, req_addr         : write enable, byte address
//   req_wdata, req_be        : write data, per-lane byte enables
//   resp_valid/resp_ready    : response handshake
//   resp_rdata, resp_err     : read data (0 on writes/errors), error flag
// Requests are accepted only while a credit is free; credits cover every
// slot in the read pipeline plus the response FIFO, so the FIFO can never
// overflow and the pipeline never needs to stall.
module data_mem_hs
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned RESP_DEPTH = 4,
  parameter              INIT_FILE  = ""
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err
);

  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned OFS    = $clog2(BE_W);
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CRED_W = $clog2(RESP_DEPTH + 1);

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] rdata;
  } resp_t;

  localparam int unsigned RESP_W = $bits(resp_t);

  logic [DATA_W-1:0] mem [DEPTH];

  addr_chk_t         chk;
  logic              acc_err;
  logic [IDX_W-1:0]  idx;
  logic              accept;
  logic              pop;
  logic [DATA_W-1:0] rd_word;
  logic [CRED_W-1:0] credits;

  logic [LATENCY-1:0] pipe_valid;
  resp_t              pipe_resp [LATENCY];

  resp_t             head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CRED_W-1:0] fifo_count;

  assign chk     = addr_check(64'(req_addr), OFS, DEPTH);
  assign acc_err = chk.misaligned | chk.out_of_range;
  assign idx     = IDX_W'(req_addr >> OFS);

  assign req_ready = (credits != '0) && rst_n;
  assign accept    = req_valid && req_ready;

  // Gating with rst_n keeps the response channel quiet for the whole
  // reset window, including the very first reset edge.
  assign resp_valid = !fifo_empty && rst_n;
  assign pop        = resp_valid && resp_ready;
  assign resp_rdata = resp_valid ? head.rdata : '0;
  assign resp_err   = resp_valid ? head.err   : 1'b0;

  // Memory array: byte-lane writes at the accept edge, never reset.
  always_ff @(posedge clk) begin
    if (accept && req_we && !acc_err) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (req_be[i]) begin
          mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (!req_we && !acc_err) begin
      rd_word = mem[idx];
    end
  end

  // Read pipeline: stage 0 captures the array at the accept edge; the
  // last stage feeds the response FIFO.
  always_ff @(posedge clk) begin
    pipe_resp[0] <= '{err: acc_err, rdata: rd_word};
    for (int unsigned i = 1; i < LATENCY; i++) begin
      pipe_resp[i] <= pipe_resp[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= accept;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      credits <= CRED_W'(RESP_DEPTH);
    end else if (accept && !pop) begin
      credits <= credits - CRED_W'(1);
    end else if (pop && !accept) begin
      credits <= credits + CRED_W'(1);
    end
  end

  resp_fifo #(
    .WIDTH (RESP_W),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (pipe_valid[LATENCY-1]),
    .wdata (pipe_resp[LATENCY-1]),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (LATENCY >= 1 && LATENCY <= LATENCY_MAX)
        else $error("LATENCY outside supported range");
      assert (int'(credits) + $countones(pipe_valid) + int'(fifo_count)
              == int'(RESP_DEPTH))
        else $error("credit accounting broken");
      assert (!(pipe_valid[LATENCY-1] && fifo_full && !pop))
        else $error("response fifo overflow");
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_hs.sv
// Scoreboard bench for data_mem_hs: requests update a word-array reference
// model and queue the expected response; a monitor compares every pop.
module tb_data_mem_hs;

    localparam int DATA_W     = 32;
    localparam int DEPTH      = 1024;
    localparam int ADDR_W     = 32;
    localparam int LATENCY    = 2;
    localparam int RESP_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic [3:0]        req_be = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    always #5 clk = ~clk;

    data_mem_hs #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .LATENCY    (LATENCY),
        .RESP_DEPTH (RESP_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        bit          chk_lat;
        int          acc;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] model [DEPTH];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stalls = 0;
    int resp_cnt = 0;
    int stream_first = -1;
    bit stream_mark = 0;
    bit rand_rdy = 0;
    bit rdy_set = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Single driver of resp_ready, updated just after each rising edge.
    always @(posedge clk) begin
        #2;
        if (rand_rdy) resp_ready = ($urandom_range(0, 3) != 0);
        else          resp_ready = rdy_set;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: word array with byte lanes, errors by plain arithmetic.
    function automatic exp_t model_access(input logic we, input logic [31:0] addr,
                                          input logic [31:0] wdata, input logic [3:0] be);
        exp_t        e;
        int unsigned widx;
        widx    = addr / 4;
        e.err   = ((addr % 4) != 0) || (widx >= DEPTH);
        e.rdata = 32'h0;
        e.chk_lat = 0;
        e.acc   = 0;
        if (!e.err) begin
            if (we) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) model[widx][8*i +: 8] = wdata[8*i +: 8];
            end else begin
                e.rdata = model[widx];
            end
        end
        return e;
    endfunction

    // Monitor: pops compared against the scoreboard; held outputs must not move.
    logic [32:0] held;
    bit          held_v = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && resp_valid) begin
            if (held_v) check("hold_stable", {resp_err, resp_rdata}, held);
            if (resp_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got rdata=%0h err=%0b with no request outstanding",
                             resp_rdata, resp_err);
                end else begin
                    e = expq.pop_front();
                    check("rdata", resp_rdata, e.rdata);
                    check("err", resp_err, e.err);
                    if (e.chk_lat) check("latency", cyc - e.acc, LATENCY);
                end
                if (stream_mark && stream_first < 0) stream_first = cyc;
                resp_cnt++;
                held_v = 0;
            end else begin
                held   = {resp_err, resp_rdata};
                held_v = 1;
            end
        end else begin
            held_v = 0;
        end
    end

    // Entered and left at posedge+#1; back-to-back calls keep req_valid high.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input bit chk_lat);
        exp_t e;
        int   waited = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            waited++;
            stalls++;
            if (waited > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: req_ready stayed %0b for %0d cycles", req_ready, waited);
                req_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        e         = model_access(we, addr, wdata, be);
        e.chk_lat = chk_lat;
        e.acc     = cyc + 1;
        expq.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Holds a read request for a fixed number of cycles, counting accepts.
    task automatic burst_reads(input int cycles, output int acc);
        exp_t e;
        acc       = 0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'($urandom_range(0, 15) * 4);
        repeat (cycles) begin
            @(negedge clk);
            if (req_ready) begin
                e = model_access(1'b0, req_addr, '0, '0);
                e.chk_lat = 0;
                expq.push_back(e);
                acc++;
            end
            @(posedge clk);
            #1;
            req_addr = 32'($urandom_range(0, 15) * 4);
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (expq.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (expq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses still outstanding", expq.size());
            expq.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_resp_err", resp_err, 0);
    endtask

    initial begin
        int acc;
        int r;
        logic [31:0] a;

        // Reset then idle
        rst_n   = 1'b0;
        rdy_set = 1'b1;
        repeat (2) check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_req_ready", req_ready, 1);
        check("post_rst_resp_valid", resp_valid, 0);
        check("post_rst_credits", dut.credits, RESP_DEPTH);
        @(posedge clk);
        #1;

        // Give the words used below defined contents
        for (int i = 0; i < 16; i++) issue(1'b1, 32'(i * 4), $urandom, 4'hF, 0);
        wait_drain();

        // Directed write/read with latency checks
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1); wait_drain();
        issue(1'b0, 32'h10, '0, '0, 1);             wait_drain();
        issue(1'b1, 32'h10, 32'h00005500, 4'b0010, 1); wait_drain();
        issue(1'b0, 32'h10, '0, '0, 1);             wait_drain();
        issue(1'b1, 32'h10, 32'h12345678, 4'b0000, 1); wait_drain();
        issue(1'b0, 32'h10, '0, '0, 1);             wait_drain();
        check("model_dead55ef", model[4], 32'hDEAD55EF);

        // Error accesses, including an errored write that must not land
        issue(1'b0, 32'h13, '0, '0, 1);             wait_drain();
        issue(1'b0, 32'h1000, '0, '0, 1);           wait_drain();
        issue(1'b1, 32'h1, 32'hFFFFFFFF, 4'hF, 1);  wait_drain();
        issue(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 1); wait_drain();
        issue(1'b0, 32'h0, '0, '0, 1);              wait_drain();
        issue(1'b0, 32'h10, '0, '0, 1);             wait_drain();

        // Back-pressure: only RESP_DEPTH requests fit
        rdy_set = 1'b0;
        @(posedge clk);
        #1;
        burst_reads(8, acc);
        check("bp_accepted", acc, RESP_DEPTH);
        @(negedge clk);
        check("bp_req_ready_low", req_ready, 0);
        @(posedge clk);
        #1;
        rdy_set = 1'b1;
        @(negedge clk);
        check("bp_ready_before_pop", req_ready, 0);
        @(negedge clk);
        check("bp_ready_after_pop", req_ready, 1);
        @(posedge clk);
        #1;
        wait_drain();

        // Streaming reads: no stalls, no bubbles
        stalls       = 0;
        r            = resp_cnt;
        stream_first = -1;
        stream_mark  = 1;
        for (int i = 0; i < 100; i++) issue(1'b0, 32'($urandom_range(0, 15) * 4), '0, '0, 0);
        wait_drain();
        stream_mark = 0;
        check("stream_stalls", stalls, 0);
        check("stream_count", resp_cnt - r, 100);
        check("stream_no_bubbles", cyc - 2 - stream_first, 99);

        // Reset with responses in flight
        issue(1'b1, 32'h14, 32'hCAFEF00D, 4'hF, 0);
        wait_drain();
        rdy_set = 1'b0;
        @(posedge clk);
        #1;
        burst_reads(3, acc);
        check("inflight_accepted", acc, 3);
        rst_n = 1'b0;
        expq.delete();
        repeat (2) check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        rdy_set = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("flushed_resp_valid", resp_valid, 0);
        end
        @(posedge clk);
        #1;
        issue(1'b0, 32'h14, '0, '0, 1);
        wait_drain();
        check("persist_model", model[5], 32'hCAFEF00D);

        // Randomized traffic with random back-pressure
        rand_rdy = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            r = $urandom_range(0, 9);
            if (r == 0)      a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            else if (r == 1) a = 32'((DEPTH + $urandom_range(0, 100)) * 4);
            else             a = 32'($urandom_range(0, 15) * 4);
            issue($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom_range(0, 15)), 0);
        end
        rand_rdy = 0;
        rdy_set  = 1'b1;
        wait_drain();
        check("final_queue_empty", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, %0d checks so far", checks);
        $fatal(1, "timeout");
    end

endmodule
